mem_read_arbiter: RTL and testbench

//  Shares the single read port of the 2048x32 program/data BRAM between N requesters (fetch, load, ...).

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_read_arbiter_rr.sv | 29 ++
 rtl/mem_read_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_read_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_read_arbiter shared types
// BRAM read-port sharing: sizes, tag, FSM
package mem_arb_pkg;
  localparam int N_REQ   = 2;
  localparam int MEM_LAT = 2;
  localparam int DEPTH_W = 11;
  localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [ID_W-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    err;
  } tag_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN,
    HOLD
  } arb_state_e;

  // misaligned or beyond the BRAM word range
  function automatic logic addr_err(
    input logic [31:0] a
  );
    return (a[1:0] != 2'b00) ||
           (a[31:DEPTH_W+2] != '0);
  endfunction
endpackage

// File: rtl/mem_read_arbiter_rr.sv
// Round-robin pick for mem_read_arbiter
// i_req/i_ptr in; one-hot o_gnt and its index o_idx out
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N = N_REQ
) (
  input  logic [N-1:0] i_req,
  input  req_id_t      i_ptr,
  output logic [N-1:0] o_gnt,
  output req_id_t      o_idx
);
  logic w_found;

  // scan starts one past the last winner
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!w_found &&
          i_req[(int'(i_ptr) + i) % N]) begin
        w_found = 1'b1;
        o_gnt[(int'(i_ptr) + i) % N] = 1'b1;
        o_idx = req_id_t'((int'(i_ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one BRAM read port among N_REQ requesters
// in: clk rst req_valid req_addr stall flush mem_q
// out: req_ready mem_read_en mem_addr resp_* busy
module mem_read_arbiter
  import mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*32-1:0] req_addr,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               stall,
  input  logic               flush,
  output logic               mem_read_en,
  output logic [31:0]        mem_addr,
  input  logic [31:0]        mem_q,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [31:0]        resp_data,
  output logic               resp_err,
  output logic               busy
);
  arb_state_e               r_state;
  req_id_t                  r_ptr;
  tag_t [MEM_LAT-1:0]       r_pipe;

  logic                     w_grant_ok;
  logic [N_REQ-1:0]         w_req;
  logic [N_REQ-1:0]         w_gnt;
  req_id_t                  w_idx;
  logic                     w_issue;
  logic [31:0]              w_addr;
  logic                     w_pipe_any;
  tag_t                     w_last;

  // grants only while not stalled/flushed and
  // the FSM is not draining or holding
  assign w_grant_ok = !rst && !stall && !flush &&
                      (r_state == IDLE ||
                       r_state == ACTIVE);
  assign w_req = w_grant_ok ? req_valid : '0;

  rr_arbiter #(
    .N(N_REQ)
  ) u_rr (
    .i_req(w_req),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx)
  );

  assign w_issue     = |w_gnt;
  assign w_addr      = req_addr[32*int'(w_idx) +: 32];
  assign req_ready   = w_gnt;
  assign mem_read_en = w_issue;
  assign mem_addr    = w_issue ? w_addr : '0;

  always_comb begin
    w_pipe_any = 1'b0;
    for (int k = 0; k < MEM_LAT; k++) begin
      w_pipe_any = w_pipe_any | r_pipe[k].valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= req_id_t'(N_REQ - 1);
    end else if (w_issue) begin
      r_ptr <= w_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= '{valid: w_issue,
                     id:    w_idx,
                     err:   addr_err(w_addr)};
      for (int k = 1; k < MEM_LAT; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
      if (flush) begin
        for (int k = 0; k < MEM_LAT; k++) begin
          r_pipe[k].valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_issue) r_state <= ACTIVE;
        end
        ACTIVE: begin
          if (flush) begin
            r_state <= stall ? HOLD : IDLE;
          end else if (stall) begin
            r_state <= w_pipe_any ? DRAIN : HOLD;
          end else if (!w_pipe_any && !w_issue) begin
            r_state <= IDLE;
          end
        end
        DRAIN: begin
          if (flush || !w_pipe_any) begin
            r_state <= stall ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (!stall) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // last tag stage is the registered response strobe
  assign w_last = r_pipe[MEM_LAT-1];

  always_comb begin
    resp_valid = '0;
    if (w_last.valid) resp_valid[w_last.id] = 1'b1;
  end

  assign resp_data = w_last.valid ? mem_q : '0;
  assign resp_err  = w_last.valid & w_last.err;
  assign busy      = (r_state != IDLE) | w_pipe_any;
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter
// BRAM model, queue-based reference, random traffic
module tb_mem_read_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [1:0]  req_ready;
  logic        stall;
  logic        flush;
  logic        mem_read_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_q;
  logic [1:0]  resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  mem_read_arbiter dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_ready(req_ready),
    .stall(stall),
    .flush(flush),
    .mem_read_en(mem_read_en),
    .mem_addr(mem_addr),
    .mem_q(mem_q),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] bram [0:2047];
  logic [31:0] q1;

  always @(posedge clk) begin
    q1    <= mem_read_en ? bram[mem_addr[12:2]] : 32'h0;
    mem_q <= q1;
  end

  typedef struct {
    int          due;
    int          id;
    logic [31:0] addr;
  } rec_t;

  rec_t q[$];
  int   mptr;
  int   cyc_n;
  int   n_cmp;
  int   n_bad;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_data(
    input logic [31:0] a
  );
    return bram[(a >> 2) % 2048];
  endfunction

  function automatic logic ref_err(
    input logic [31:0] a
  );
    return (a % 4 != 0) || (a >= (4 << DEPTH_W));
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0: a = ($urandom_range(0, 2047) << 2) |
             $urandom_range(1, 3);
      1: a = $urandom | 32'h0000_2000;
      default: a = $urandom_range(0, 2047) << 2;
    endcase
    return a;
  endfunction

  // one clock: drive, then check against the
  // queue of outstanding reads
  task automatic cyc(
    input logic [1:0]  v,
    input logic [31:0] a0,
    input logic [31:0] a1,
    input logic        st,
    input logic        fl,
    input bit          gok
  );
    int          w;
    logic [31:0] ea;
    logic [1:0]  eg;
    rec_t        r;
    @(negedge clk);
    cyc_n++;
    req_valid = v;
    req_addr  = {a1, a0};
    stall     = st;
    flush     = fl;
    #1;
    w  = -1;
    ea = 32'h0;
    if (gok) begin
      for (int i = 1; i <= 2; i++) begin
        int j;
        j = (mptr + i) % 2;
        if (w < 0 && v[j]) w = j;
      end
    end
    eg = (w < 0) ? 2'b00 : 2'(1 << w);
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("mem_read_en", 32'(mem_read_en),
        (w >= 0) ? 32'd1 : 32'd0);
    if (w >= 0) begin
      ea = (w == 0) ? a0 : a1;
      chk("mem_addr", mem_addr, ea);
    end
    if (q.size() > 0) chk("busy", 32'(busy), 32'd1);
    if (q.size() > 0 && q[0].due == cyc_n) begin
      r = q.pop_front();
      chk("resp_valid", 32'(resp_valid),
          32'(1 << r.id));
      chk("resp_data", resp_data, ref_data(r.addr));
      chk("resp_err", 32'(resp_err),
          32'(ref_err(r.addr)));
    end else begin
      chk("resp_valid", 32'(resp_valid), 32'd0);
      chk("resp_data", resp_data, 32'd0);
    end
    if (fl) q.delete();
    if (w >= 0) begin
      q.push_back('{cyc_n + MEM_LAT, w, ea});
      mptr = w;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  v;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        fl;
    n_cmp = 0;
    n_bad = 0;
    cyc_n = 0;
    mptr  = 1;
    for (int i = 0; i < 2048; i++) begin
      bram[i] = 32'hA000_0000 + i;
    end
    rst       = 1'b1;
    req_valid = 2'b00;
    req_addr  = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    #2 req_valid = 2'b11;
    #5;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_en", 32'(mem_read_en), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rv", 32'(resp_valid), 32'd0);
    chk("rst_rd", resp_data, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 2'b00;

    // contention: 0,1,0,1
    cyc(2'b11, 32'h0, 32'h4, 1'b0, 1'b0, 1'b1);
    chk("cont_first", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, 32'h0, 32'h4, 1'b0, 1'b0, 1'b1);
    end
    idle(3);

    // single
    cyc(2'b01, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("single_rv", 32'(resp_valid), 32'd1);
    chk("single_rd", resp_data, 32'hA000_0004);
    idle(1);

    // errors
    cyc(2'b10, 32'h0, 32'h6, 1'b0, 1'b0, 1'b1);
    cyc(2'b10, 32'h0, 32'h2000, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("mis_err", 32'(resp_err), 32'd1);
    chk("mis_rv", 32'(resp_valid), 32'd2);
    idle(1);
    chk("oor_err", 32'(resp_err), 32'd1);
    chk("oor_rd", resp_data, 32'hA000_0000);
    idle(2);

    // stall after one issue
    cyc(2'b01, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(2'b01, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    cyc(2'b01, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("stall_idle", 32'(busy), 32'd0);
    idle(2);

    // flush squashes the in-flight read
    cyc(2'b01, 32'h8, 32'h0, 1'b0, 1'b0, 1'b1);
    cyc(2'b01, 32'hC, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("flush_busy", 32'(busy), 32'd0);
    idle(3);

    // async reset one cycle after issue
    cyc(2'b01, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_en", 32'(mem_read_en), 32'd0);
    chk("arst_rv", 32'(resp_valid), 32'd0);
    chk("arst_rd", resp_data, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 2'b00;
    q.delete();
    mptr = 1;
    idle(4);

    // random traffic with flushes
    for (int i = 0; i < 400; i++) begin
      v  = 2'($urandom_range(0, 3));
      a0 = rand_addr();
      a1 = rand_addr();
      fl = ($urandom_range(0, 9) == 0);
      cyc(v, a0, a1, 1'b0, fl, !fl);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
